// File: rtl/armleocpu_ptw_arbiter.sv
// Round-robin arbiter that shares one Sv32 page table walker between the fetch
// (requester 0) and data (requester 1) TLB miss paths, with flush cancellation.
module armleocpu_ptw_arbiter #(
  parameter int unsigned VPN_W = 20,
  parameter int unsigned PPN_W = 22
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             flush,

  input  logic             req0_resolve_request,
  input  logic [VPN_W-1:0] req0_resolve_virtual_address,
  output logic             req0_resolve_ack,
  output logic             req0_resolve_pagefault,
  output logic             req0_resolve_accessfault,
  output logic [PPN_W-1:0] req0_resolve_physical_address,
  output logic [7:0]       req0_resolve_metadata,

  input  logic             req1_resolve_request,
  input  logic [VPN_W-1:0] req1_resolve_virtual_address,
  output logic             req1_resolve_ack,
  output logic             req1_resolve_pagefault,
  output logic             req1_resolve_accessfault,
  output logic [PPN_W-1:0] req1_resolve_physical_address,
  output logic [7:0]       req1_resolve_metadata,

  output logic             ptw_resolve_request,
  output logic [VPN_W-1:0] ptw_resolve_virtual_address,
  input  logic             ptw_resolve_done,
  input  logic             ptw_resolve_pagefault,
  input  logic             ptw_resolve_accessfault,
  input  logic [PPN_W-1:0] ptw_resolve_physical_address,
  input  logic [7:0]       ptw_resolve_metadata
);

  // Bit 1 set exactly in the states that keep the walker busy.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RESP = 2'b01,
    WALK = 2'b10,
    DROP = 2'b11
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [VPN_W-1:0] vpn_q;

  logic             pf0_q, af0_q, pf1_q, af1_q;
  logic [PPN_W-1:0] ppn0_q, ppn1_q;
  logic [7:0]       meta0_q, meta1_q;

  logic             req_any_c;
  logic             grant_sel_c;
  logic [VPN_W-1:0] grant_vpn_c;

  // On a tie the requester that did not win last time gets the walker.
  always_comb begin
    req_any_c   = req0_resolve_request | req1_resolve_request;
    grant_sel_c = (req0_resolve_request & req1_resolve_request) ? ~last_grant
                                                                : req1_resolve_request;
    grant_vpn_c = grant_sel_c ? req1_resolve_virtual_address
                              : req0_resolve_virtual_address;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      vpn_q      <= '0;
      pf0_q      <= 1'b0;
      af0_q      <= 1'b0;
      ppn0_q     <= '0;
      meta0_q    <= '0;
      pf1_q      <= 1'b0;
      af1_q      <= 1'b0;
      ppn1_q     <= '0;
      meta1_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && req_any_c) begin
            owner      <= grant_sel_c;
            last_grant <= grant_sel_c;
            vpn_q      <= grant_vpn_c;
            state      <= WALK;
          end
        end
        WALK: begin
          if (ptw_resolve_done) begin
            if (!flush) begin
              // Only the owner's result registers change; the other side holds.
              if (owner) begin
                pf1_q   <= ptw_resolve_pagefault;
                af1_q   <= ptw_resolve_accessfault;
                ppn1_q  <= ptw_resolve_physical_address;
                meta1_q <= ptw_resolve_metadata;
              end else begin
                pf0_q   <= ptw_resolve_pagefault;
                af0_q   <= ptw_resolve_accessfault;
                ppn0_q  <= ptw_resolve_physical_address;
                meta0_q <= ptw_resolve_metadata;
              end
              state <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        // Walker cannot be aborted: wait out its transaction, then discard.
        DROP: begin
          if (ptw_resolve_done) begin
            state <= IDLE;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ptw_resolve_request         = state[1];
  assign ptw_resolve_virtual_address = vpn_q;

  // Ack is the single combinational path: a flush in RESP suppresses it.
  assign req0_resolve_ack = (state == RESP) && !owner && !flush;
  assign req1_resolve_ack = (state == RESP) &&  owner && !flush;

  assign req0_resolve_pagefault        = pf0_q;
  assign req0_resolve_accessfault      = af0_q;
  assign req0_resolve_physical_address = ppn0_q;
  assign req0_resolve_metadata         = meta0_q;

  assign req1_resolve_pagefault        = pf1_q;
  assign req1_resolve_accessfault      = af1_q;
  assign req1_resolve_physical_address = ppn1_q;
  assign req1_resolve_metadata         = meta1_q;

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// Directed bench for armleocpu_ptw_arbiter: arbitration order, latency, result
// routing, flush cancellation and asynchronous reset.
module tb_armleocpu_ptw_arbiter;

  localparam int unsigned VPN_W = 20;
  localparam int unsigned PPN_W = 22;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             r0, r1;
  logic [VPN_W-1:0] va0, va1;
  logic             ack0, pf0, af0, ack1, pf1, af1;
  logic [PPN_W-1:0] pa0, pa1;
  logic [7:0]       md0, md1;
  logic             ptw_req;
  logic [VPN_W-1:0] ptw_va;
  logic             done, wpf, waf;
  logic [PPN_W-1:0] wppn;
  logic [7:0]       wmeta;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  armleocpu_ptw_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .clk                           (clk),
    .async_rst_n                   (rst_n),
    .flush                         (flush),
    .req0_resolve_request          (r0),
    .req0_resolve_virtual_address  (va0),
    .req0_resolve_ack              (ack0),
    .req0_resolve_pagefault        (pf0),
    .req0_resolve_accessfault      (af0),
    .req0_resolve_physical_address (pa0),
    .req0_resolve_metadata         (md0),
    .req1_resolve_request          (r1),
    .req1_resolve_virtual_address  (va1),
    .req1_resolve_ack              (ack1),
    .req1_resolve_pagefault        (pf1),
    .req1_resolve_accessfault      (af1),
    .req1_resolve_physical_address (pa1),
    .req1_resolve_metadata         (md1),
    .ptw_resolve_request           (ptw_req),
    .ptw_resolve_virtual_address   (ptw_va),
    .ptw_resolve_done              (done),
    .ptw_resolve_pagefault         (wpf),
    .ptw_resolve_accessfault       (waf),
    .ptw_resolve_physical_address  (wppn),
    .ptw_resolve_metadata          (wmeta)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ptw_req"}, 32'(ptw_req), 32'd0);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
  endtask

  // Walker finishes this cycle; check the ack cycle, owner drops, then IDLE.
  task automatic do_done(input string tag, input int who, input logic [PPN_W-1:0] p,
                         input logic [7:0] m, input logic pfv, input logic afv);
    done = 1'b1; wppn = p; wmeta = m; wpf = pfv; waf = afv;
    step();
    done = 1'b0; wpf = 1'b0; waf = 1'b0; wppn = '0; wmeta = '0;
    if (who == 0) begin
      chk({tag, "_ack0"}, 32'(ack0), 32'd1);
      chk({tag, "_ack1"}, 32'(ack1), 32'd0);
      chk({tag, "_pa0"}, 32'(pa0), 32'(p));
      chk({tag, "_md0"}, 32'(md0), 32'(m));
      chk({tag, "_pf0"}, 32'(pf0), 32'(pfv));
      chk({tag, "_af0"}, 32'(af0), 32'(afv));
      r0 = 1'b0;
    end else begin
      chk({tag, "_ack1"}, 32'(ack1), 32'd1);
      chk({tag, "_ack0"}, 32'(ack0), 32'd0);
      chk({tag, "_pa1"}, 32'(pa1), 32'(p));
      chk({tag, "_md1"}, 32'(md1), 32'(m));
      chk({tag, "_pf1"}, 32'(pf1), 32'(pfv));
      chk({tag, "_af1"}, 32'(af1), 32'(afv));
      r1 = 1'b0;
    end
    step();
    chk_idle({tag, "_idle"});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    r0 = 1'b0; r1 = 1'b0; va0 = '0; va1 = '0;
    done = 1'b0; wpf = 1'b0; waf = 1'b0; wppn = '0; wmeta = '0;
    #1;
    chk_idle("rst");
    chk("rst_ptw_va", 32'(ptw_va), 32'd0);
    chk("rst_pa0", 32'(pa0), 32'd0);
    chk("rst_pa1", 32'(pa1), 32'd0);
    #11;
    rst_n = 1'b1;

    // Tie from reset: requester 0 first, requester 1 two cycles after done.
    r0 = 1'b1; va0 = 20'h00001; r1 = 1'b1; va1 = 20'h00002;
    step();
    chk("tie_ptw_req", 32'(ptw_req), 32'd1);
    chk("tie_ptw_va0", 32'(ptw_va), 32'h00001);
    step();
    do_done("tie_a", 0, 22'h000111, 8'h01, 1'b0, 1'b0);
    step();
    chk("tie_ptw_req1", 32'(ptw_req), 32'd1);
    chk("tie_ptw_va1", 32'(ptw_va), 32'h00002);
    // Second tie presented while requester 1 is still finishing.
    r0 = 1'b1; va0 = 20'h00003; va1 = 20'h00004;
    do_done("tie_b", 1, 22'h000222, 8'h03, 1'b0, 1'b0);
    r1 = 1'b1;
    step();
    chk("tie2_ptw_req", 32'(ptw_req), 32'd1);
    chk("tie2_ptw_va", 32'(ptw_va), 32'h00003);
    do_done("tie_c", 0, 22'h000333, 8'h07, 1'b0, 1'b0);
    r1 = 1'b0;

    // Single fetch miss, done three cycles after the request.
    r0 = 1'b1; va0 = 20'hF00A1;
    step();
    chk("fetch_ptw_req", 32'(ptw_req), 32'd1);
    chk("fetch_ptw_va", 32'(ptw_va), 32'hF00A1);
    chk("fetch_ack1_c1", 32'(ack1), 32'd0);
    step();
    chk("fetch_ack0_c2", 32'(ack0), 32'd0);
    step();
    do_done("fetch", 0, 22'h001000, 8'h0F, 1'b0, 1'b0);
    chk("fetch_pa1_hold", 32'(pa1), 32'h000222);

    // Fault routing to requester 1.
    r1 = 1'b1; va1 = 20'h12345;
    step();
    chk("pf_ptw_va", 32'(ptw_va), 32'h12345);
    do_done("pf", 1, 22'h000ABC, 8'h5B, 1'b1, 1'b0);
    chk("pf_pf0_quiet", 32'(pf0), 32'd0);
    r1 = 1'b1; va1 = 20'h54321;
    step();
    do_done("af", 1, 22'h3ABCDE, 8'hC3, 1'b0, 1'b1);

    // Flush mid-walk: DROP keeps the walker busy, no ack, discarded result.
    r0 = 1'b1; va0 = 20'h0AAAA;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    r1 = 1'b1; va1 = 20'h0BBBB;
    chk("drop_ptw_req", 32'(ptw_req), 32'd1);
    chk("drop_ack0", 32'(ack0), 32'd0);
    step();
    chk("drop_ptw_req2", 32'(ptw_req), 32'd1);
    chk("drop_ptw_va", 32'(ptw_va), 32'h0AAAA);
    done = 1'b1; wppn = 22'h155555; wmeta = 8'hFF;
    step();
    done = 1'b0;
    chk_idle("drop_done");
    chk("drop_pa0_hold", 32'(pa0), 32'h001000);
    step();
    chk("drop_next_req", 32'(ptw_req), 32'd1);
    chk("drop_next_va", 32'(ptw_va), 32'h0BBBB);
    do_done("after_drop", 1, 22'h000042, 8'h11, 1'b0, 1'b0);

    // Flush on the done cycle: no ack, straight back to IDLE.
    r0 = 1'b1;
    step();
    chk("fd_ptw_va", 32'(ptw_va), 32'h0AAAA);
    done = 1'b1; flush = 1'b1; wppn = 22'h0000FF;
    step();
    done = 1'b0; flush = 1'b0;
    chk_idle("fd");
    step();
    chk("fd_regrant", 32'(ptw_req), 32'd1);

    // Flush in RESP suppresses the ack; flush held in IDLE blocks one grant.
    done = 1'b1; wppn = 22'h2468AC; wmeta = 8'h5A;
    step();
    done = 1'b0;
    flush = 1'b1;
    #1;
    chk("fr_ack0", 32'(ack0), 32'd0);
    chk("fr_ack1", 32'(ack1), 32'd0);
    step();
    chk_idle("fr_idle");
    step();
    chk("fi_blocked", 32'(ptw_req), 32'd0);
    flush = 1'b0;
    step();
    chk("fi_grant", 32'(ptw_req), 32'd1);

    // Asynchronous reset mid-walk restores last_grant, so the tie goes to 0.
    r1 = 1'b1; va0 = 20'h0C0C0; va1 = 20'h0D0D0;
    rst_n = 1'b0;
    #1;
    chk_idle("amid");
    chk("amid_pa0", 32'(pa0), 32'd0);
    chk("amid_ptw_va", 32'(ptw_va), 32'd0);
    rst_n = 1'b1;
    step();
    chk("arst_tie_req", 32'(ptw_req), 32'd1);
    chk("arst_tie_va", 32'(ptw_va), 32'h0C0C0);
    do_done("arst", 0, 22'h3FFFFF, 8'hA5, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/armleocpu_ptw_arbiter.md
# armleocpu_ptw_arbiter

Shares one Sv32 page table walker between the instruction-fetch TLB miss path (requester 0) and the data TLB miss path (requester 1). Grants the walker round-robin, holds one walk in flight, and routes the PPN, metadata and fault result back only to the requester that owns the walk. A flush, asserted on a satp change or sfence.vma, cancels delivery of an in-flight walk without aborting the walker's memory transaction.

## Interface
Parameters:
- VPN_W, 20, virtual page number width (Sv32 VA[31:12])
- PPN_W, 22, physical page number width (Sv32)

Ports:
- clk  in  1  clock, all state updates on rising edge
- async_rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  cancel pending grant and in-flight response
- reqN_resolve_request  in  1  N∈{0,1}; level; held high with stable VA until the matching ack
- reqN_resolve_virtual_address  in  VPN_W  VPN to resolve
- reqN_resolve_ack  out  1  one-cycle pulse, result valid
- reqN_resolve_pagefault  out  1  walk ended in page fault
- reqN_resolve_accessfault  out  1  walk ended in access fault
- reqN_resolve_physical_address  out  PPN_W  resolved PPN (megapage: low 10 bits = VPN[9:0])
- reqN_resolve_metadata  out  8  PTE bits [7:0] (D A G U X W R V)
- ptw_resolve_request  out  1  level; high for the whole walk
- ptw_resolve_virtual_address  out  VPN_W  latched VPN of the current owner
- ptw_resolve_done  in  1  one-cycle pulse from the walker
- ptw_resolve_pagefault, ptw_resolve_accessfault  in  1  walker result, valid with done
- ptw_resolve_physical_address  in  PPN_W  walker result, valid with done
- ptw_resolve_metadata  in  8  walker result, valid with done

## Operation
- States: IDLE, WALK, DROP, RESP. State, owner, last_grant, latched VPN and result registers are all flops.
- IDLE with flush=0:
  - If any request is high, grant it. When both are high, grant the one not equal to last_grant.
  - Latch the VPN, set owner and last_grant, go to WALK.
  - flush=1 in IDLE blocks the grant that cycle.
- WALK: ptw_resolve_request=1, ptw_resolve_virtual_address = latched VPN.
  - done with flush=0: capture the result into registers, go to RESP.
  - done with flush=1: go to IDLE, no ack.
  - flush=1 without done: go to DROP. The walker cannot be aborted.
- DROP: ptw_resolve_request stays 1. On done, go to IDLE and discard the result. Further flushes have no effect.
- RESP: reqN_resolve_ack for the owner = !flush. Result outputs are driven from registers. Always go to IDLE next.
  - RESP gives a one-cycle bubble so the owner can drop its request before the next arbitration.
- The non-owner's ack is always 0.
- Result outputs are valid only while ack is high. Outside ack they hold their last captured value.
- Requester inputs are ignored outside IDLE. A request that changes VA while not yet granted is sampled at grant time.
- A walker done pulse outside WALK/DROP is ignored.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0, VPN register=0.
  - All result registers 0; all acks 0; ptw_resolve_request=0.
- ptw_resolve_request is decoded from registered state, glitch-free.
- Latency, with a request seen in IDLE at cycle 0:
  - ptw_resolve_request high at cycle 1.
  - Walker done at cycle k gives ack at cycle k+1 and IDLE at k+2.
  - Minimum total latency is 2 cycles plus the walker time.
- Back-to-back: the second requester is granted at cycle k+2, with ptw_resolve_request high at k+3.
- reqN_resolve_ack is combinationally gated by flush in RESP. It is the only combinational input-to-output path.
- Reset asserted mid-walk returns to reset values immediately. The walker shares async_rst_n.

## Test plan
- Single fetch miss: req0 VPN=20'hF00A1; walker done 3 cycles later with PPN=22'h001000, meta=8'h0F → ptw request high cycle 1 with VPN F00A1, req0 ack at done+1 with PPN 001000, meta 0F; req1 ack never asserted.
- Tie: req0 and req1 both high from reset, VPN 20'h00001 / 20'h00002 → req0 walked first, then req1 granted 2 cycles after req0's done. Repeat the tie → req0 wins again (alternating after last_grant=1).
- Fault routing: req1 only; walker done with pagefault=1 → req1 ack with pagefault=1, accessfault=0; repeat with accessfault=1 → correspondingly flagged.
- Flush mid-walk: grant req0, flush one cycle in WALK → state DROP, ptw request stays high until done, no ack; next request granted on the cycle after done.
- Flush on the done cycle and flush in RESP → no ack in either case; arbiter returns to IDLE; flush in IDLE with req0 high → no grant that cycle, grant the next cycle.
- Reset during WALK (async_rst_n low for 1ns) → ptw request and acks 0 immediately; after release, a tie is won by req0.
